fwd_scoreboard: RTL and testbench

- Parametrised successor to the fixed E/M/W forwarding network in the CPU top.
- Tracks every in-flight register write across STAGES pipeline stages: destination register plus a per-entry countdown of stages until its value is available.
- Resolves READ_PORTS operand requests in one pass, returning either the forwarded value, the register-file value, or a wait (bubble) request.
- Sits beside the decode stage; its stage-advance and bubble rules follow the same thermometer stall scheme as the pipeline.

---
 rtl/fwd_scoreboard.sv | 156 +++++++++++++++
 tb/tb_fwd_scoreboard.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: parametrised operand-forwarding scoreboard.
//
// Tracks in-flight register writes across STAGES pipeline stages (0=E, 1=M,
// 2=W for the default depth). Each stage holds one entry {valid, dest,
// remain}, where remain counts the stage advances still needed before the
// producer's value appears on stage_data. Stage movement follows the
// pipeline's thermometer stall vector: a held stage keeps its entry, and a
// free stage whose upstream neighbour is held receives a bubble.
//
// READ_PORTS lookups are resolved combinationally from the current entries.
// The youngest matching producer wins. A ready producer forwards its stage
// data, and a producer that is not yet ready raises a wait.
//
// Optional build macro: SCOREBOARD_STATS_EN
//   When defined, adds the 32-bit stall_cycles and fwd_count statistics
//   counters and their output ports.

module fwd_scoreboard #(
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int LAT_W      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_W-1:0]            issue_dest,
    input  logic [LAT_W-1:0]                 issue_lat,
    input  logic [STAGES-1:0]                stall,
    input  logic [STAGES*DATA_W-1:0]         stage_data,
    input  logic [READ_PORTS-1:0]            req_en,
    input  logic [READ_PORTS*REG_ADDR_W-1:0] req_addr,
    input  logic [READ_PORTS*DATA_W-1:0]     rf_value,
    output logic [READ_PORTS*DATA_W-1:0]     fwd_value,
    output logic [READ_PORTS-1:0]            fwd_hit,
    output logic [READ_PORTS-1:0]            fwd_wait,
    output logic                             any_wait,
    output logic [$clog2(STAGES+1)-1:0]      occupancy
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      fwd_count
`endif
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Per-stage scoreboard entries.
    logic                  entryValid  [STAGES];
    logic [REG_ADDR_W-1:0] entryDest   [STAGES];
    logic [LAT_W-1:0]      entryRemain [STAGES];

    // Per-port flag: a youngest producer has already been found for this port.
    logic [READ_PORTS-1:0] portMatched;

    // Advance, hold or bubble every stage according to the thermometer stall vector.
    // NOTE: only the valid bits are reset; dest and remain are never looked at
    // while an entry is invalid, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                entryValid[i] <= 1'b0;
            end
        end else begin
            // Stage 0 takes the issuing instruction unless it is held. Register 0
            // is never tracked, and an issue is ignored while stage 0 is held.
            if (!stall[0]) begin
                entryValid[0]  <= issue_valid && (issue_dest != '0);
                entryDest[0]   <= issue_dest;
                entryRemain[0] <= issue_lat;
            end

            // Later stages either take the upstream entry, which is one stage
            // closer to ready, or become a bubble when upstream is held. A held
            // stage keeps its countdown frozen.
            for (int i = 1; i < STAGES; i++) begin
                if (!stall[i]) begin
                    if (!stall[i-1]) begin
                        entryValid[i]  <= entryValid[i-1];
                        entryDest[i]   <= entryDest[i-1];
                        entryRemain[i] <= (entryRemain[i-1] == '0) ? '0
                                        : entryRemain[i-1] - LAT_W'(1);
                    end else begin
                        entryValid[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Resolve each read port against the youngest matching producer.
    // NOTE: blocking assignments here are intentional. portMatched must see its
    // own update from an earlier stage within the same pass of the scan.
    always_comb begin
        fwd_value   = rf_value;
        fwd_hit     = '0;
        fwd_wait    = '0;
        portMatched = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (req_en[p] && (req_addr[p*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                for (int i = 0; i < STAGES; i++) begin
                    if (!portMatched[p] && entryValid[i] &&
                        (entryDest[i] == req_addr[p*REG_ADDR_W +: REG_ADDR_W])) begin
                        portMatched[p] = 1'b1;
                        if (entryRemain[i] == '0) begin
                            fwd_hit[p]                   = 1'b1;
                            fwd_value[p*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
                        end else begin
                            fwd_wait[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Any port waiting means the caller must hold decode.
    assign any_wait = |fwd_wait;

    // Count valid entries currently in flight.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(entryValid[i]);
        end
    end

`ifdef SCOREBOARD_STATS_EN
    localparam int HIT_W = $clog2(READ_PORTS + 1);

    logic [HIT_W-1:0] hitCount;

    // Number of ports forwarding from a stage this cycle.
    always_comb begin
        hitCount = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            hitCount = hitCount + HIT_W'(fwd_hit[p]);
        end
    end

    // Free-running statistics counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            fwd_count    <= '0;
        end else begin
            if (any_wait) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            fwd_count <= fwd_count + 32'(hitCount);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed bench for fwd_scoreboard. A queue model tracks
// each in-flight instruction by its position and issue latency, and a
// per-cycle compare process checks the DUT against that model. Literal
// expectations pin the model at the key scenarios.

module tb_fwd_scoreboard;

    localparam int STAGES     = 3;
    localparam int READ_PORTS = 2;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int LAT_W      = 2;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             issue_valid;
    logic [REG_ADDR_W-1:0]            issue_dest;
    logic [LAT_W-1:0]                 issue_lat;
    logic [STAGES-1:0]                stall;
    logic [STAGES*DATA_W-1:0]         stage_data;
    logic [READ_PORTS-1:0]            req_en;
    logic [READ_PORTS*REG_ADDR_W-1:0] req_addr;
    logic [READ_PORTS*DATA_W-1:0]     rf_value;
    logic [READ_PORTS*DATA_W-1:0]     fwd_value;
    logic [READ_PORTS-1:0]            fwd_hit;
    logic [READ_PORTS-1:0]            fwd_wait;
    logic                             any_wait;
    logic [$clog2(STAGES+1)-1:0]      occupancy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]                      stall_cycles;
    logic [31:0]                      fwd_count;
`endif

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .STAGES(STAGES), .READ_PORTS(READ_PORTS), .REG_ADDR_W(REG_ADDR_W),
        .DATA_W(DATA_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_lat(issue_lat),
        .stall(stall), .stage_data(stage_data),
        .req_en(req_en), .req_addr(req_addr), .rf_value(rf_value),
        .fwd_value(fwd_value), .fwd_hit(fwd_hit), .fwd_wait(fwd_wait),
        .any_wait(any_wait), .occupancy(occupancy)
`ifdef SCOREBOARD_STATS_EN
        , .stall_cycles(stall_cycles), .fwd_count(fwd_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An instruction is ready once it has advanced at least 'lat' stages.
    typedef struct {
        int dest;
        int lat;
        int pos;
    } instr_t;

    instr_t inflight[$];
    instr_t nextQ[$];
    instr_t tmpInstr;
`ifdef SCOREBOARD_STATS_EN
    int unsigned mStall = 0;
    int unsigned mFwd   = 0;
    logic        sHit, sWait;
    logic [31:0] sVal;
    int          sHits;
    bit          sAny;
`endif

    function automatic void modelLookup(input logic en, input int addr, input logic [31:0] rf,
                                        output logic hit, output logic wt, output logic [31:0] val);
        int best = -1;
        int bestLat = 0;
        hit = 1'b0;
        wt  = 1'b0;
        val = rf;
        if (en && addr != 0) begin
            foreach (inflight[k]) begin
                if (inflight[k].dest == addr && (best < 0 || inflight[k].pos < best)) begin
                    best    = inflight[k].pos;
                    bestLat = inflight[k].lat;
                end
            end
        end
        if (best >= 0) begin
            if (best >= bestLat) begin
                hit = 1'b1;
                val = stage_data[best*DATA_W +: DATA_W];
            end else begin
                wt = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            inflight.delete();
`ifdef SCOREBOARD_STATS_EN
            mStall = 0;
            mFwd   = 0;
`endif
        end else begin
`ifdef SCOREBOARD_STATS_EN
            sHits = 0;
            sAny  = 1'b0;
            for (int p = 0; p < READ_PORTS; p++) begin
                modelLookup(req_en[p], int'(req_addr[p*REG_ADDR_W +: REG_ADDR_W]),
                            rf_value[p*DATA_W +: DATA_W], sHit, sWait, sVal);
                if (sHit)  sHits++;
                if (sWait) sAny = 1'b1;
            end
            if (sAny) mStall++;
            mFwd += sHits;
`endif
            nextQ.delete();
            foreach (inflight[k]) begin
                if (stall[inflight[k].pos]) begin
                    nextQ.push_back(inflight[k]);
                end else if (inflight[k].pos < STAGES - 1) begin
                    tmpInstr     = inflight[k];
                    tmpInstr.pos = tmpInstr.pos + 1;
                    nextQ.push_back(tmpInstr);
                end
            end
            if (!stall[0] && issue_valid && issue_dest != 0) begin
                tmpInstr.dest = int'(issue_dest);
                tmpInstr.lat  = int'(issue_lat);
                tmpInstr.pos  = 0;
                nextQ.push_back(tmpInstr);
            end
            inflight = nextQ;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        eHit, eWait;
    logic [31:0] eVal;
    bit          eAny;

    always @(negedge clk) begin
        if (checkOn) begin
            eAny = 1'b0;
            for (int p = 0; p < READ_PORTS; p++) begin
                modelLookup(req_en[p], int'(req_addr[p*REG_ADDR_W +: REG_ADDR_W]),
                            rf_value[p*DATA_W +: DATA_W], eHit, eWait, eVal);
                check($sformatf("model_value_p%0d", p), 64'(fwd_value[p*DATA_W +: DATA_W]), 64'(eVal));
                check($sformatf("model_hit_p%0d", p), 64'(fwd_hit[p]), 64'(eHit));
                check($sformatf("model_wait_p%0d", p), 64'(fwd_wait[p]), 64'(eWait));
                if (eWait) eAny = 1'b1;
            end
            check("model_any_wait", 64'(any_wait), 64'(eAny));
            check("model_occupancy", 64'(occupancy), 64'(inflight.size()));
`ifdef SCOREBOARD_STATS_EN
            check("model_stall_cycles", 64'(stall_cycles), 64'(mStall));
            check("model_fwd_count", 64'(fwd_count), 64'(mFwd));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clockIn(input logic v, input logic [REG_ADDR_W-1:0] d,
                           input logic [LAT_W-1:0] l, input logic [STAGES-1:0] st);
        issue_valid = v;
        issue_dest  = d;
        issue_lat   = l;
        stall       = st;
        @(posedge clk);
        #1;
    endtask

    task automatic setPort(input int p, input logic en, input logic [REG_ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] rf);
        req_en[p]                           = en;
        req_addr[p*REG_ADDR_W +: REG_ADDR_W] = a;
        rf_value[p*DATA_W +: DATA_W]         = rf;
    endtask

    task automatic setData(input int s, input logic [DATA_W-1:0] d);
        stage_data[s*DATA_W +: DATA_W] = d;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic                  v;
        logic [REG_ADDR_W-1:0] d;
        logic [LAT_W-1:0]      l;
        logic [STAGES-1:0]     st;
    } step_t;

    step_t steps[12] = '{
        '{1'b1, 5'd12, 2'd3, 3'b000}, '{1'b1, 5'd13, 2'd2, 3'b000},
        '{1'b0, 5'd0,  2'd0, 3'b001}, '{1'b0, 5'd0,  2'd0, 3'b011},
        '{1'b0, 5'd0,  2'd0, 3'b000}, '{1'b1, 5'd12, 2'd0, 3'b000},
        '{1'b0, 5'd0,  2'd0, 3'b111}, '{1'b0, 5'd0,  2'd0, 3'b000},
        '{1'b1, 5'd13, 2'd1, 3'b000}, '{1'b0, 5'd0,  2'd0, 3'b000},
        '{1'b0, 5'd0,  2'd0, 3'b000}, '{1'b0, 5'd0,  2'd0, 3'b000}
    };

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        issue_lat   = 2'd0;
        stall       = '0;
        req_en      = '0;
        req_addr    = '0;
        rf_value    = '0;
        stage_data  = '0;
        setData(0, 32'h100);
        setData(1, 32'h101);
        setData(2, 32'h102);

        // Reset held with an issue pending, then released.
        @(posedge clk);
        #1;
        checkOn = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        issue_valid = 1'b0;
        setPort(0, 1'b1, 5'd5, 32'h11);
        settle();
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_value", 64'(fwd_value[31:0]), 64'h11);
        check("reset_hit", 64'(fwd_hit), 64'd0);
        check("reset_wait", 64'(fwd_wait), 64'd0);

        // Load-use: producer with one stage of latency.
        setPort(0, 1'b0, 5'd0, 32'h0);
        clockIn(1'b1, 5'd8, 2'd1, 3'b000);
        setPort(0, 1'b1, 5'd8, 32'h22);
        settle();
        check("loaduse_wait", 64'(fwd_wait[0]), 64'd1);
        check("loaduse_any_wait", 64'(any_wait), 64'd1);
        check("loaduse_value_rf", 64'(fwd_value[31:0]), 64'h22);
        clockIn(1'b0, 5'd0, 2'd0, 3'b001);
        settle();
        check("loaduse_held_wait", 64'(fwd_wait[0]), 64'd1);
        check("loaduse_held_occ", 64'(occupancy), 64'd1);
        setData(1, 32'hDEAD);
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);
        settle();
        check("loaduse_hit", 64'(fwd_hit[0]), 64'd1);
        check("loaduse_fwd_value", 64'(fwd_value[31:0]), 64'hDEAD);
        check("loaduse_no_wait", 64'(any_wait), 64'd0);
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);

        // Youngest producer wins.
        setPort(0, 1'b0, 5'd0, 32'h0);
        clockIn(1'b1, 5'd3, 2'd0, 3'b000);
        clockIn(1'b1, 5'd3, 2'd0, 3'b000);
        setData(0, 32'hA);
        setData(1, 32'hB);
        setPort(1, 1'b1, 5'd3, 32'h33);
        settle();
        check("youngest_value", 64'(fwd_value[63:32]), 64'hA);
        check("youngest_hit", 64'(fwd_hit[1]), 64'd1);
        check("youngest_occ", 64'(occupancy), 64'd2);

        // A young, unready producer shadows an older, ready one.
        clockIn(1'b1, 5'd4, 2'd0, 3'b000);
        clockIn(1'b1, 5'd4, 2'd2, 3'b000);
        setPort(0, 1'b1, 5'd4, 32'h44);
        settle();
        check("shadow_wait", 64'(fwd_wait[0]), 64'd1);
        check("shadow_hit", 64'(fwd_hit[0]), 64'd0);
        check("shadow_value", 64'(fwd_value[31:0]), 64'h44);

        // Register 0 is never tracked.
        clockIn(1'b1, 5'd0, 2'd0, 3'b000);
        setPort(0, 1'b1, 5'd0, 32'h0);
        settle();
        check("r0_hit", 64'(fwd_hit[0]), 64'd0);
        check("r0_wait", 64'(fwd_wait[0]), 64'd0);
        check("r0_value", 64'(fwd_value[31:0]), 64'd0);
        check("r0_occ", 64'(occupancy), 64'd2);

        // Bubble insertion below a held stage 1.
        clockIn(1'b1, 5'd6, 2'd0, 3'b000);
        clockIn(1'b1, 5'd7, 2'd0, 3'b000);
        clockIn(1'b1, 5'd9, 2'd0, 3'b000);
        settle();
        check("bubble_pre_occ", 64'(occupancy), 64'd3);
        setPort(0, 1'b1, 5'd6, 32'h66);
        setPort(1, 1'b1, 5'd9, 32'h99);
        setData(0, 32'h900);
        clockIn(1'b1, 5'd10, 2'd0, 3'b011);
        settle();
        check("bubble_occ", 64'(occupancy), 64'd2);
        check("bubble_r6_gone", 64'(fwd_value[31:0]), 64'h66);
        check("bubble_r9_held", 64'(fwd_value[63:32]), 64'h900);
        clockIn(1'b1, 5'd11, 2'd0, 3'b111);
        settle();
        check("fullhold_occ", 64'(occupancy), 64'd2);

        // Directed sequence exercising saturation and mixed stalls.
        setPort(0, 1'b1, 5'd12, 32'h1212);
        setPort(1, 1'b1, 5'd13, 32'h1313);
        setData(0, 32'hC0);
        setData(1, 32'hC1);
        setData(2, 32'hC2);
        foreach (steps[k]) begin
            clockIn(steps[k].v, steps[k].d, steps[k].l, steps[k].st);
        end

        // Reset overrides a simultaneous issue and full stall.
        clockIn(1'b1, 5'd12, 2'd0, 3'b000);
        reset = 1'b0;
        clockIn(1'b1, 5'd14, 2'd0, 3'b111);
        settle();
        check("rst_override_occ", 64'(occupancy), 64'd0);
        check("rst_override_hit", 64'(fwd_hit), 64'd0);
        check("rst_override_value", 64'(fwd_value[31:0]), 64'h1212);

`ifdef SCOREBOARD_STATS_EN
        check("stats_reset_stall", 64'(stall_cycles), 64'd0);
        check("stats_reset_fwd", 64'(fwd_count), 64'd0);
        setPort(0, 1'b0, 5'd0, 32'h0);
        setPort(1, 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        clockIn(1'b1, 5'd8, 2'd1, 3'b000);
        setPort(0, 1'b1, 5'd8, 32'h1);
        for (int n = 0; n < 4; n++) begin
            clockIn(1'b0, 5'd0, 2'd0, 3'b001);
        end
        setPort(0, 1'b0, 5'd0, 32'h0);
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);
        setPort(0, 1'b1, 5'd8, 32'h1);
        setPort(1, 1'b1, 5'd8, 32'h2);
        for (int n = 0; n < 3; n++) begin
            clockIn(1'b0, 5'd0, 2'd0, 3'b111);
        end
        setPort(0, 1'b0, 5'd0, 32'h0);
        setPort(1, 1'b0, 5'd0, 32'h0);
        settle();
        check("stats_stall_cycles", 64'(stall_cycles), 64'd4);
        check("stats_fwd_count", 64'(fwd_count), 64'd6);
        reset = 1'b0;
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);
        settle();
        check("stats_clear_stall", 64'(stall_cycles), 64'd0);
        check("stats_clear_fwd", 64'(fwd_count), 64'd0);
`endif

        reset = 1'b1;
        clockIn(1'b0, 5'd0, 2'd0, 3'b000);
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
